// File: rtl/fetch_control_if.sv
// Instruction-memory request/response channel between the fetch sequencer and imem.
// Requests are req/gnt qualified; responses return in order on rvalid.
interface fetch_control_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_control.sv
// Instruction-fetch sequencer: owns the fetch PC, issues imem requests, queues returned
// words in order and hands one instruction per cycle to execute; flushes on redirect.
module fetch_control #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          QDEPTH    = 2,
    parameter int          MAX_OUTST = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_en,
    fetch_control_if.master         imem,
    input  logic                    pc_v_x,
    input  logic [31:0]             pc_x,
    output logic [31:0]             pc_o,
    output logic                    inst_v_o,
    output logic [31:0]             inst_o,
    output logic                    busy
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(2 * QDEPTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [31:0]      pc_mem   [QDEPTH];
    logic [31:0]      inst_mem [QDEPTH];
    logic             req, fire, rsp, drop, push, pop;

    always_comb begin
        // Queue slots already promised to live (non-discarded) requests count as used.
        inflight = count_q + outst_q - discard_q;
        req  = (state_q == RUN) && fetch_en && !pc_v_x
               && (outst_q < CNT_W'(MAX_OUTST)) && (inflight < CNT_W'(QDEPTH));
        fire = req && imem.gnt;
        rsp  = imem.rvalid && (outst_q != '0);
        drop = rsp && (discard_q != '0);
        push = rsp && !drop && !pc_v_x;
        pop  = (count_q != '0) && !pc_v_x;

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q + CNT_W'(fire) - CNT_W'(rsp);
        discard_d  = discard_q - CNT_W'(drop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        wptr_d     = wptr_q + PTR_W'(push);
        rptr_d     = rptr_q + PTR_W'(pop);

        if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
        if (push) rsp_pc_d = rsp_pc_q + 32'd4;

        // Everything still in flight at a redirect belongs to the wrong path.
        if (pc_v_x) begin
            fetch_pc_d = pc_x & ~32'd3;
            rsp_pc_d   = pc_x & ~32'd3;
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            discard_d  = outst_d;
        end

        case (state_q)
            IDLE:    if (fetch_en) state_d = RUN;
            RUN:     if (!fetch_en && (outst_q == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr_q]   <= rsp_pc_q;
            inst_mem[wptr_q] <= imem.rdata;
        end
    end

    assign imem.req  = req;
    assign imem.addr = fetch_pc_q;
    assign inst_v_o  = pop;
    assign pc_o      = pc_mem[rptr_q];
    assign inst_o    = inst_mem[rptr_q];
    assign busy      = (outst_q != '0) || (count_q != '0);
endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control: a deep-queue instance for streaming/redirect/stall/reset
// scenarios and a default-size instance starting near the top of the address space.
module tb_fetch_control;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fen_a, pcv_a, gnt_a, hold_a;
    logic [31:0] pcx_a;
    logic [31:0] pc_a, inst_a;
    logic        iv_a, busy_a;
    logic        fen_b;
    logic [31:0] pc_b, inst_b;
    logic        iv_b, busy_b;
    int          checks = 0;
    int          fails = 0;

    fetch_control_if ifa ();
    fetch_control_if ifb ();

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    fetch_control #(.RESET_PC(32'h0000_0000), .QDEPTH(4), .MAX_OUTST(2)) dut_a (
        .clk(clk), .reset(reset), .fetch_en(fen_a), .imem(ifa),
        .pc_v_x(pcv_a), .pc_x(pcx_a), .pc_o(pc_a), .inst_v_o(iv_a), .inst_o(inst_a),
        .busy(busy_a));

    fetch_control #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .reset(reset), .fetch_en(fen_b), .imem(ifb),
        .pc_v_x(1'b0), .pc_x(32'h0), .pc_o(pc_b), .inst_v_o(iv_b), .inst_o(inst_b),
        .busy(busy_b));

    // imem models: in-order, response one cycle after grant unless held back
    logic [31:0] gq_a[$];
    logic [31:0] gq_b[$];
    assign ifa.gnt = gnt_a;
    assign ifb.gnt = 1'b1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            gq_a.delete();
            ifa.rvalid <= 1'b0;
            ifa.rdata  <= 32'h0;
        end else begin
            if (ifa.req && ifa.gnt) gq_a.push_back(ifa.addr);
            if (!hold_a && gq_a.size() > 0) begin
                ifa.rvalid <= 1'b1;
                ifa.rdata  <= word_of(gq_a.pop_front());
            end else begin
                ifa.rvalid <= 1'b0;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            gq_b.delete();
            ifb.rvalid <= 1'b0;
            ifb.rdata  <= 32'h0;
        end else begin
            if (ifb.req && ifb.gnt) gq_b.push_back(ifb.addr);
            if (gq_b.size() > 0) begin
                ifb.rvalid <= 1'b1;
                ifb.rdata  <= word_of(gq_b.pop_front());
            end else begin
                ifb.rvalid <= 1'b0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: reset just released, fetch_en high.
    task automatic start_a(input logic h);
        reset = 1'b1; fen_a = 1'b0; pcv_a = 1'b0; pcx_a = 32'h0; gnt_a = 1'b1; hold_a = h;
        fen_b = 1'b0;
        tick; tick;
        reset = 1'b0; fen_a = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; fen_a = 1'b1; pcv_a = 1'b0; pcx_a = 32'h0; gnt_a = 1'b1; hold_a = 1'b0;
        fen_b = 1'b1;
        tick; tick;
        checks++; if (ifa.req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", ifa.req); end
        checks++; if (iv_a !== 1'b0) begin fails++; $display("FAIL reset_inst_v: got %b want 0", iv_a); end
        checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        checks++; if ({ifb.req, iv_b, busy_b} !== 3'b000) begin fails++; $display("FAIL reset_b_outputs: got %b want 000", {ifb.req, iv_b, busy_b}); end
        fen_b = 1'b0;
    endtask

    task automatic test_stream;
        start_a(1'b0);
        checks++; if (ifa.req !== 1'b0) begin fails++; $display("FAIL stream_c0_req: got %b want 0", ifa.req); end
        tick;
        checks++; if ({ifa.req, ifa.addr} !== {1'b1, 32'h0}) begin fails++; $display("FAIL stream_c1_req: got %b/%h want 1/00000000", ifa.req, ifa.addr); end
        tick;
        checks++; if (iv_a !== 1'b0) begin fails++; $display("FAIL stream_c2_no_bypass: got %b want 0", iv_a); end
        tick;
        checks++; if ({iv_a, pc_a, inst_a} !== {1'b1, 32'h0, word_of(32'h0)}) begin fails++; $display("FAIL stream_c3_first: got %b/%h/%h want 1/00000000/%h", iv_a, pc_a, inst_a, word_of(32'h0)); end
        for (int k = 1; k <= 6; k++) begin
            tick;
            checks++; if ({iv_a, pc_a} !== {1'b1, 32'(4 * k)}) begin fails++; $display("FAIL stream_sustain: got %b/%h want 1/%h", iv_a, pc_a, 32'(4 * k)); end
        end
    endtask

    task automatic test_branch;
        logic got, seen_req;
        // two requests in flight, memory held back, then redirect
        start_a(1'b1);
        tick; tick;
        tick;
        pcv_a = 1'b1; pcx_a = 32'h0000_0103;
        #1;
        checks++; if ({iv_a, ifa.req, busy_a} !== 3'b001) begin fails++; $display("FAIL branch_cycle: got v/req/busy %b want 001", {iv_a, ifa.req, busy_a}); end
        tick;
        pcv_a = 1'b0; hold_a = 1'b0;
        #1;
        checks++; if (ifa.req !== 1'b0) begin fails++; $display("FAIL branch_outst_full: got %b want 0", ifa.req); end
        got = 1'b0; seen_req = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick;
            if (ifa.req && !seen_req) begin
                seen_req = 1'b1;
                checks++; if (ifa.addr !== 32'h100) begin fails++; $display("FAIL branch_new_addr: got %h want 00000100", ifa.addr); end
            end
            if (iv_a) begin
                got = 1'b1;
                checks++; if ({pc_a, inst_a} !== {32'h100, word_of(32'h100)}) begin fails++; $display("FAIL branch_first_pc: got %h/%h want 00000100/%h", pc_a, inst_a, word_of(32'h100)); end
            end
        end
        if (!got) begin checks++; fails++; $display("FAIL branch_timeout: got no delivery want pc 00000100"); end
        tick;
        checks++; if ({iv_a, pc_a} !== {1'b1, 32'h104}) begin fails++; $display("FAIL branch_second_pc: got %b/%h want 1/00000104", iv_a, pc_a); end

        // redirect with a valid head and a response arriving in the same cycle
        start_a(1'b0);
        tick; tick;
        tick;
        pcv_a = 1'b1; pcx_a = 32'h0000_0200;
        #1;
        checks++; if ({iv_a, ifa.req} !== 2'b00) begin fails++; $display("FAIL branch_head_hidden: got v/req %b want 00", {iv_a, ifa.req}); end
        tick;
        pcv_a = 1'b0;
        #1;
        checks++; if ({ifa.req, ifa.addr} !== {1'b1, 32'h200}) begin fails++; $display("FAIL branch_restart_req: got %b/%h want 1/00000200", ifa.req, ifa.addr); end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick;
            if (iv_a) begin
                got = 1'b1;
                checks++; if (pc_a !== 32'h200) begin fails++; $display("FAIL branch_head_flushed: got %h want 00000200", pc_a); end
            end
        end
        if (!got) begin checks++; fails++; $display("FAIL branch_head_timeout: got no delivery want pc 00000200"); end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_pc;
        int n;
        start_a(1'b0);
        exp_pc = 32'h0; n = 0;
        for (int c = 1; c <= 16; c++) begin
            tick;
            gnt_a = !(c >= 3 && c <= 7);
            #1;
            if (c >= 3 && c <= 7) begin
                checks++; if ({ifa.req, ifa.addr} !== {1'b1, 32'h8}) begin fails++; $display("FAIL bp_req_stable: cycle %0d got %b/%h want 1/00000008", c, ifa.req, ifa.addr); end
            end
            if (c >= 5 && c <= 7) begin
                checks++; if (iv_a !== 1'b0) begin fails++; $display("FAIL bp_drained: cycle %0d got %b want 0", c, iv_a); end
            end
            if (iv_a) begin
                checks++; if ({pc_a, inst_a} !== {exp_pc, word_of(exp_pc)}) begin fails++; $display("FAIL bp_order: got %h/%h want %h/%h", pc_a, inst_a, exp_pc, word_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                n++;
            end
        end
        checks++; if (n !== 9) begin fails++; $display("FAIL bp_count: got %0d deliveries want 9", n); end
        gnt_a = 1'b1;
    endtask

    task automatic test_fetch_en_drain;
        logic [31:0] exp_pc;
        int n;
        start_a(1'b1);
        tick; tick;
        tick;
        fen_a = 1'b0; hold_a = 1'b0;
        #1;
        exp_pc = 32'h0; n = 0;
        for (int c = 3; c <= 9; c++) begin
            if (c > 3) tick;
            checks++; if (ifa.req !== 1'b0) begin fails++; $display("FAIL fen_no_req: cycle %0d got %b want 0", c, ifa.req); end
            if (iv_a) begin
                checks++; if (pc_a !== exp_pc) begin fails++; $display("FAIL fen_order: got %h want %h", pc_a, exp_pc); end
                exp_pc = exp_pc + 32'd4;
                n++;
            end
        end
        checks++; if (n !== 2) begin fails++; $display("FAIL fen_count: got %0d want 2", n); end
        checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL fen_busy: got %b want 0", busy_a); end
        fen_a = 1'b1;
        #1;
        checks++; if (ifa.req !== 1'b0) begin fails++; $display("FAIL fen_idle_state: got req %b want 0", ifa.req); end
        tick;
        checks++; if ({ifa.req, ifa.addr} !== {1'b1, 32'h8}) begin fails++; $display("FAIL fen_resume: got %b/%h want 1/00000008", ifa.req, ifa.addr); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc;
        int n;
        start_a(1'b0);
        fen_a = 1'b0; fen_b = 1'b1;
        exp_pc = 32'hFFFF_FFF8; n = 0;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (c == 1) begin
                checks++; if ({ifb.req, ifb.addr} !== {1'b1, 32'hFFFF_FFF8}) begin fails++; $display("FAIL wrap_first_req: got %b/%h want 1/fffffff8", ifb.req, ifb.addr); end
            end
            if (iv_b && n < 3) begin
                checks++; if ({pc_b, inst_b} !== {exp_pc, word_of(exp_pc)}) begin fails++; $display("FAIL wrap_pc: got %h/%h want %h/%h", pc_b, inst_b, exp_pc, word_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                n++;
            end
        end
        checks++; if (n !== 3) begin fails++; $display("FAIL wrap_count: got %0d want 3", n); end
        fen_b = 1'b0;
    endtask

    task automatic test_async_reset;
        start_a(1'b0);
        for (int c = 1; c <= 5; c++) tick;
        #2;
        checks++; if ({ifa.req, iv_a, busy_a} !== 3'b111) begin fails++; $display("FAIL areset_pre: got req/v/busy %b want 111", {ifa.req, iv_a, busy_a}); end
        reset = 1'b1;
        #1;
        checks++; if ({ifa.req, iv_a, busy_a} !== 3'b000) begin fails++; $display("FAIL areset_immediate: got req/v/busy %b want 000", {ifa.req, iv_a, busy_a}); end
        tick;
        reset = 1'b0;
        #1;
        tick;
        checks++; if ({ifa.req, ifa.addr} !== {1'b1, 32'h0}) begin fails++; $display("FAIL areset_restart: got %b/%h want 1/00000000", ifa.req, ifa.addr); end
        tick; tick;
        checks++; if ({iv_a, pc_a} !== {1'b1, 32'h0}) begin fails++; $display("FAIL areset_first_pc: got %b/%h want 1/00000000", iv_a, pc_a); end
    endtask

    initial begin
        fen_a = 1'b0; pcv_a = 1'b0; pcx_a = 32'h0; gnt_a = 1'b1; hold_a = 1'b0; fen_b = 1'b0;
        test_reset;
        test_stream;
        test_branch;
        test_backpressure;
        test_fetch_en_drain;
        test_wrap;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
